sbox1_inv: RTL and testbench
============================

SBOX1_INV -- requirements
Module: sbox1_inv

Interface
REQ-001 The block SHALL have exactly one parameter: CHECK_BIJ, default 1, which enables duplicate-output detection during build.
REQ-002 The port list SHALL be as follows, in this order:
- clk  input  1  sole clock; all state rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rebuild  input  1  single-cycle pulse that requests a table rebuild.
- s1_x  output  8  index driven to an external SBOX1 instance.
- s1_y  input  8  combinational S1 result for s1_x.
- init_done  output  1  inverse table valid; lookups accepted.
- dup_err  output  1  sticky flag; the last build found a non-bijective S1.
- in_valid  input  1  lookup request valid.
- in_ready  output  1  lookup request accepted when high with in_valid.
- in_data  input  8  value y to invert.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8  x such that S1[x] = in_data.

Function
REQ-003 The FSM SHALL have states BUILD and SERVE, with BUILD entered on reset release.
REQ-004 In BUILD, an 8-bit counter cnt SHALL drive s1_x = cnt and advance from 0x00 to 0xFF, one entry per cycle.
REQ-005 In BUILD, each cycle SHALL write inv[s1_y] = cnt into an internal 256x8 table and set seen[s1_y].
REQ-006 If CHECK_BIJ = 1 and seen[s1_y] is already set at the time of the write, dup_err SHALL set; the write still occurs.
REQ-007 After the write at cnt = 0xFF, the FSM SHALL enter SERVE, with init_done high on the next cycle; a build takes exactly 256 cycles.
REQ-008 Outside BUILD, s1_x SHALL hold 0x00.
REQ-009 in_ready SHALL equal init_done AND (NOT out_valid OR out_ready).
REQ-010 On an in_valid AND in_ready edge, out_data SHALL load inv[in_data] and out_valid SHALL set; lookup latency is exactly 1 cycle.
REQ-011 Throughput SHALL be 1 lookup per cycle when out_ready is held high.
REQ-012 out_valid AND NOT out_ready SHALL hold out_data and out_valid stable.
REQ-013 When out_valid AND out_ready hold and no new accept occurs in the same cycle, out_valid SHALL clear.
REQ-014 When an accept and a drain coincide, out_valid SHALL stay high and out_data SHALL take the new value.
REQ-015 A rebuild pulse in SERVE SHALL do all of the following on the next edge:
- clear init_done and out_valid; any pending result is discarded;
- clear dup_err and all seen bits;
- set cnt = 0 and enter BUILD.
REQ-016 A rebuild pulse during BUILD SHALL be ignored.
REQ-017 A rebuild pulse that coincides with an accepted lookup SHALL take priority; that lookup is dropped.
REQ-018 in_ready SHALL be low throughout BUILD.

Reset
REQ-019 rst_n low SHALL asynchronously force the following values:
- state = BUILD, cnt = 0x00;
- init_done = 0, dup_err = 0, out_valid = 0, out_data = 0x00;
- all seen bits cleared.
REQ-020 Table contents SHALL NOT be reset; they are overwritten by the build.
REQ-021 Reset asserted mid-build or mid-transfer SHALL abort it; the build restarts from 0x00 after release.

Structure
REQ-022 A shared package clefia_pkg SHALL hold:
- BYTE_W = 8 and SBOX_DEPTH = 256;
- the state enum type sbox_inv_state_t.
REQ-023 The table with its write port and registered read port SHALL be one sub-module, sbox_ram_256x8; the SBOX1 instance stays external and connects through s1_x/s1_y.
REQ-024 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Reset release with real SBOX1 attached -> init_done rises exactly 257 cycles after rst_n rises; dup_err = 0.
- After build, in_data 0x57, 0x49, 0xD1 back-to-back with out_ready = 1 -> out_data 0x00, 0x01, 0x02 on consecutive cycles.
- Exhaustive sweep of y = 0x00..0xFF -> SBOX1[out_data] == y for every y.
- out_ready held low for 5 cycles with out_valid set -> in_ready = 0 and out_data unchanged; on release, next accept proceeds.
- Stub S1 returning 0x00 for x = 0x10 and 0x20 -> dup_err = 1 after build; a rebuild with the real SBOX1 clears it.
- rst_n pulsed low at cnt = 0x80, and rebuild pulsed in SERVE with out_valid = 1 -> out_valid drops, init_done drops, and the full 256-cycle build repeats.

Source files
------------

// File: rtl/clefia_pkg.sv
// Shared widths and state type for the CLEFIA S-box inverse table block.
package clefia_pkg;

    localparam int BYTE_W     = 8;
    localparam int SBOX_DEPTH = 256;

    typedef enum logic [0:0] {
        ST_BUILD = 1'b0,
        ST_SERVE = 1'b1
    } sbox_inv_state_t;

endpackage

// File: rtl/sbox1_inv_if.sv
// Lookup request/response stream of the SBOX1 inverse block.
interface sbox1_inv_if;
    import clefia_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sbox_ram_256x8.sv
// 256x8 inverse table: one write port, one registered read port.
module sbox_ram_256x8
    import clefia_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BYTE_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [BYTE_W-1:0] raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_r [SBOX_DEPTH];
    logic [BYTE_W-1:0] rdata_r;

    // Table storage; every build rewrites all entries, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read register doubles as the lookup result and holds while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= {BYTE_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/sbox1_inv.sv
// Builds the inverse of an external SBOX1 by sweeping it, then serves lookups.
module sbox1_inv
    import clefia_pkg::*;
#(
    parameter int unsigned CHECK_BIJ = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rebuild,
    output logic [BYTE_W-1:0] s1_x,
    input  logic [BYTE_W-1:0] s1_y,
    output logic              init_done,
    output logic              dup_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data
);

    sbox_inv_state_t       state_r;
    logic [BYTE_W-1:0]     cnt_r;
    logic                  init_done_r;
    logic                  dup_err_r;
    logic                  out_valid_r;
    logic [SBOX_DEPTH-1:0] seen_r;

    logic build_s;
    logic rebuild_s;
    logic in_ready_s;
    logic accept_s;
    logic dup_hit_s;

    // Handshake and control decode; a rebuild in SERVE drops a coincident lookup.
    always_comb begin
        build_s    = (state_r == ST_BUILD);
        rebuild_s  = rebuild && (state_r == ST_SERVE);
        in_ready_s = init_done_r && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s && !rebuild_s;
        dup_hit_s  = (CHECK_BIJ != 32'd0) && seen_r[s1_y];
    end

    // Build/serve FSM; cnt wraps to zero on leaving BUILD so s1_x idles at 0x00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BUILD;
            cnt_r       <= 8'h00;
            init_done_r <= 1'b0;
            dup_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
            seen_r      <= {SBOX_DEPTH{1'b0}};
        end else begin
            case (state_r)
                ST_BUILD: begin
                    seen_r[s1_y] <= 1'b1;
                    if (dup_hit_s) begin
                        dup_err_r <= 1'b1;
                    end
                    cnt_r <= cnt_r + 8'd1;
                    if (cnt_r == 8'hFF) begin
                        state_r <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (rebuild_s) begin
                        state_r     <= ST_BUILD;
                        cnt_r       <= 8'h00;
                        init_done_r <= 1'b0;
                        dup_err_r   <= 1'b0;
                        out_valid_r <= 1'b0;
                        seen_r      <= {SBOX_DEPTH{1'b0}};
                    end else begin
                        init_done_r <= 1'b1;
                        if (accept_s) begin
                            out_valid_r <= 1'b1;
                        end else if (out_ready) begin
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_BUILD;
                    cnt_r       <= 8'h00;
                    init_done_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    seen_r      <= {SBOX_DEPTH{1'b0}};
                end
            endcase
        end
    end

    sbox_ram_256x8 u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (build_s),
        .waddr (s1_y),
        .wdata (cnt_r),
        .re    (accept_s),
        .raddr (in_data),
        .rdata (out_data)
    );

    assign s1_x      = cnt_r;
    assign init_done = init_done_r;
    assign dup_err   = dup_err_r;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_sbox1_inv.sv
// Scoreboard bench for sbox1_inv with the CLEFIA SBOX1 table (and a faulty stub) attached.
module tb_sbox1_inv;
    import clefia_pkg::*;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       rebuild = 1'b0;
    logic       stub_en = 1'b0;
    logic [7:0] s1_x;
    logic [7:0] s1_y;
    logic       init_done;
    logic       dup_err;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] inv_tbl [256];

    logic [7:0] s1_tbl [256] = '{
        8'h57,8'h49,8'hd1,8'hc6,8'h2f,8'h33,8'h74,8'hfb,8'h95,8'h6d,8'h82,8'hea,8'h0e,8'hb0,8'ha8,8'h1c,
        8'h28,8'hd0,8'h4b,8'h92,8'h5c,8'hee,8'h85,8'hb1,8'hc4,8'h0a,8'h76,8'h3d,8'h63,8'hf9,8'h17,8'haf,
        8'hbf,8'ha1,8'h19,8'h65,8'hf7,8'h7a,8'h32,8'h20,8'h06,8'hce,8'he4,8'h83,8'h9d,8'h5b,8'h4c,8'hd8,
        8'h42,8'h5d,8'h2e,8'he8,8'hd4,8'h9b,8'h0f,8'h13,8'h3c,8'h89,8'h67,8'hc0,8'h71,8'haa,8'hb6,8'hf5,
        8'ha4,8'hbe,8'hfd,8'h8c,8'h12,8'h00,8'h97,8'hda,8'h78,8'he1,8'hcf,8'h6b,8'h39,8'h43,8'h55,8'h26,
        8'h30,8'h98,8'hcc,8'hdd,8'heb,8'h54,8'hb3,8'h8f,8'h4e,8'h16,8'hfa,8'h22,8'ha5,8'h77,8'h09,8'h61,
        8'hd6,8'h2a,8'h53,8'h37,8'h45,8'hc1,8'h6c,8'hae,8'hef,8'h70,8'h08,8'h99,8'h8b,8'h1d,8'hf2,8'hb4,
        8'he9,8'hc7,8'h9f,8'h4a,8'h31,8'h25,8'hfe,8'h7c,8'hd3,8'ha2,8'hbd,8'h56,8'h14,8'h88,8'h60,8'h0b,
        8'hcd,8'he2,8'h34,8'h50,8'h9e,8'hdc,8'h11,8'h05,8'h2b,8'hb7,8'ha9,8'h48,8'hff,8'h66,8'h8a,8'h73,
        8'h03,8'h75,8'h86,8'hf1,8'h6a,8'ha7,8'h40,8'hc2,8'hb9,8'h2c,8'hdb,8'h1f,8'h58,8'h94,8'h3e,8'hed,
        8'hfc,8'h1b,8'ha0,8'h04,8'hb8,8'h8d,8'he6,8'h59,8'h62,8'h93,8'h35,8'h7e,8'hca,8'h21,8'hdf,8'h47,
        8'h15,8'hf3,8'hba,8'h7f,8'ha6,8'h69,8'hc8,8'h4d,8'h87,8'h3b,8'h9c,8'h01,8'he0,8'hde,8'h24,8'h52,
        8'h7b,8'h0c,8'h68,8'h1e,8'h80,8'hb2,8'h5a,8'he7,8'had,8'hd5,8'h23,8'hf4,8'h46,8'h3f,8'h91,8'hc9,
        8'h6e,8'h84,8'h72,8'hbb,8'h0d,8'h18,8'hd9,8'h96,8'hf0,8'h5f,8'h41,8'hac,8'h27,8'hc5,8'he3,8'h3a,
        8'h81,8'h6f,8'h07,8'ha3,8'h79,8'hf6,8'h2d,8'h38,8'h1a,8'h44,8'h5e,8'hb5,8'hd2,8'hec,8'hcb,8'h90,
        8'h9a,8'h36,8'he5,8'h29,8'hc3,8'h4f,8'hab,8'h64,8'h51,8'hf8,8'h10,8'hd7,8'hbc,8'h02,8'h7d,8'h8e
    };

    sbox1_inv_if bif ();

    sbox1_inv #(.CHECK_BIJ(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rebuild   (rebuild),
        .s1_x      (s1_x),
        .s1_y      (s1_y),
        .init_done (init_done),
        .dup_err   (dup_err),
        .in_valid  (bif.in_valid),
        .in_ready  (bif.in_ready),
        .in_data   (bif.in_data),
        .out_valid (bif.out_valid),
        .out_ready (bif.out_ready),
        .out_data  (bif.out_data)
    );

    always #5 clk = ~clk;

    // External SBOX1; the stub collides x = 0x10 and 0x20 onto 0x00.
    always_comb begin
        if (stub_en && (s1_x == 8'h10 || s1_x == 8'h20)) begin
            s1_y = 8'h00;
        end else begin
            s1_y = s1_tbl[s1_x];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output transfer is compared against the queue head.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bif.out_valid && bif.out_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_extra: got 0x%0h, expected no output", bif.out_data);
            end else begin
                check("scoreboard", bif.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] y, input logic [7:0] exp);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = y;
        #1;
        for (int i = 0; i < 20 && !bif.in_ready; i++) begin
            @(negedge clk);
            #1;
        end
        check("send_ready", bif.in_ready, 1'b1);
        if (bif.in_ready) begin
            exp_q.push_back(exp);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_init(input int pulse_at, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            rebuild = (cycles == pulse_at);
            if (cycles == 10) begin
                check("build_in_ready", bif.in_ready, 1'b0);
                check("build_dup_clear", dup_err, 1'b0);
            end
        end while (!init_done && cycles < 400);
        rebuild = 1'b0;
    endtask

    task automatic do_rebuild();
        @(negedge clk);
        rebuild = 1'b1;
        @(posedge clk);
        #1;
        rebuild = 1'b0;
        check("rebuild_init_done", init_done, 1'b0);
        check("rebuild_out_valid", bif.out_valid, 1'b0);
        check("rebuild_s1_x", s1_x, 8'h00);
    endtask

    initial begin
        int cyc;
        int p0;
        for (int i = 0; i < 256; i++) begin
            inv_tbl[s1_tbl[i]] = 8'(i);
        end
        bif.in_valid  = 1'b0;
        bif.in_data   = 8'h00;
        bif.out_ready = 1'b1;

        // Reset state, then first build from reset release.
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_init_done", init_done, 1'b0);
        check("rst_dup_err", dup_err, 1'b0);
        check("rst_out_valid", bif.out_valid, 1'b0);
        check("rst_out_data", bif.out_data, 8'h00);
        check("rst_s1_x", s1_x, 8'h00);
        check("rst_in_ready", bif.in_ready, 1'b0);
        rst_n = 1'b1;
        wait_init(0, cyc);
        check("init_latency", cyc, 257);
        check("init_dup_err", dup_err, 1'b0);
        check("serve_s1_x", s1_x, 8'h00);

        // Back-to-back lookups must drain on consecutive cycles.
        p0 = pop_cnt;
        send(8'h57, 8'h00);
        send(8'h49, 8'h01);
        send(8'hD1, 8'h02);
        @(negedge clk);
        bif.in_valid = 1'b0;
        #3;
        check("b2b_pops", pop_cnt - p0, 3);
        repeat (2) @(negedge clk);

        // Back-pressure: result must hold and in_ready stay low.
        bif.out_ready = 1'b0;
        send(8'h49, 8'h01);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = 8'hD1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_in_ready", bif.in_ready, 1'b0);
            check("hold_out_valid", bif.out_valid, 1'b1);
            check("hold_out_data", bif.out_data, 8'h01);
            @(negedge clk);
        end
        bif.out_ready = 1'b1;
        #1;
        check("release_ready", bif.in_ready, 1'b1);
        if (bif.in_ready) begin
            exp_q.push_back(8'h02);
        end
        idle(3);

        // Exhaustive sweep of y.
        for (int y = 0; y < 256; y++) begin
            send(8'(y), inv_tbl[y]);
        end
        idle(3);
        check("sweep_drained", exp_q.size(), 0);

        // Non-bijective stub, with an ignored rebuild pulse mid-build.
        stub_en = 1'b1;
        do_rebuild();
        wait_init(100, cyc);
        check("stub_latency", cyc, 257);
        check("stub_dup_err", dup_err, 1'b1);
        stub_en = 1'b0;
        do_rebuild();
        wait_init(0, cyc);
        check("real_latency", cyc, 257);
        check("real_dup_err", dup_err, 1'b0);
        send(8'h57, 8'h00);
        idle(3);

        // Reset asserted mid-build at cnt = 0x80.
        do_rebuild();
        cyc = 0;
        while (s1_x != 8'h80 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid_build_cnt", s1_x, 8'h80);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s1_x", s1_x, 8'h00);
        check("mid_rst_init_done", init_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_init(0, cyc);
        check("rst_rebuild_latency", cyc, 257);

        // Rebuild in SERVE discards a pending result.
        bif.out_ready = 1'b0;
        send(8'h49, 8'h01);
        @(negedge clk);
        bif.in_valid = 1'b0;
        #1;
        check("pending_out_valid", bif.out_valid, 1'b1);
        do_rebuild();
        exp_q.delete();
        bif.out_ready = 1'b1;
        wait_init(0, cyc);
        check("serve_rebuild_latency", cyc, 257);
        send(8'hD1, 8'h02);
        idle(3);
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
